credit_display_scan: RTL and testbench

//  Upstream feeder for the 4-bit hex-to-7-segment decoder in the vending display path.

---
 rtl/credit_display_scan.sv | 135 +++++++++++++
 tb/tb_credit_display_scan.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/credit_display_scan.sv
// credit_display_scan: binary credit -> BCD (sequential double-dabble) and
// time-multiplexed digit scan feeding a hex-to-7-segment decoder.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading-zero digit anodes).
module credit_display_scan #(
    parameter int NUM_DIGITS       = 4,
    parameter int VALUE_W          = 14,
    parameter int REFRESH_DIV      = 50000,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [VALUE_W-1:0]    value_in,
    input  logic                  load,
    output logic                  busy,
    output logic                  overflow,
    output logic [3:0]            digit_out,
    output logic [NUM_DIGITS-1:0] anode
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(VALUE_W + 1);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [31:0]      MAX_VALUE = 32'(10 ** NUM_DIGITS - 1);
    localparam logic [BCD_W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state;
    logic [VALUE_W-1:0] shreg;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_next;
    logic [CNT_W-1:0]   bit_cnt;
    logic               ovf_pend;
    logic [BCD_W-1:0]   display;
    logic [PRE_W-1:0]   prescaler;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        value_ext;
    logic [NUM_DIGITS-1:0] lit;
    logic [NUM_DIGITS-1:0] anode_raw;

    assign value_ext = 32'(value_in);
    assign busy      = (state == SHIFT);

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the next MSB.
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[BCD_W-2:0], shreg[VALUE_W-1]};
    end

    // Conversion FSM: capture on load in IDLE, VALUE_W shift steps, then commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            bcd      <= '0;
            bit_cnt  <= '0;
            ovf_pend <= 1'b0;
            display  <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg    <= value_in;
                        bcd      <= '0;
                        bit_cnt  <= '0;
                        ovf_pend <= (value_ext > MAX_VALUE);
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd     <= bcd_next;
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    // Final step commits straight from the step result, so busy lasts VALUE_W cycles.
                    if (bit_cnt == CNT_W'(VALUE_W - 1)) begin
                        display  <= ovf_pend ? ALL_NINES : bcd_next;
                        overflow <= ovf_pend;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Free-running refresh prescaler and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            idx       <= '0;
        end else if (prescaler == PRE_W'(REFRESH_DIV - 1)) begin
            prescaler <= '0;
            idx       <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Per-digit lit mask: leading zeros blanked only when the macro is defined.
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        lit = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            lit[i] = (i == 0) || ((display >> (4 * i)) != '0);
        end
`else
        lit = '1;
`endif
    end

    // Output decode from registers only: selected nibble and one-hot anode.
    always_comb begin
        digit_out = '0;
        anode_raw = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                digit_out    = display[4*i +: 4];
                anode_raw[i] = lit[i];
            end
        end
        anode = (ANODE_ACTIVE_LOW != 0) ? ~anode_raw : anode_raw;
    end

endmodule

// File: tb/tb_credit_display_scan.sv
// Directed bench for credit_display_scan (4 digits, 14-bit value, refresh 4).
// Build with LEADING_ZERO_BLANK_EN defined to exercise leading-zero blanking.
module tb_credit_display_scan;

    logic        clk;
    logic        rst_n;
    logic [13:0] value_in;
    logic        load;
    logic        busy;
    logic        overflow;
    logic [3:0]  digit_out;
    logic [3:0]  anode;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    logic [15:0] cur_bcd = 16'h0000;
    logic        cur_ovf = 1'b0;

    credit_display_scan #(
        .NUM_DIGITS      (4),
        .VALUE_W         (14),
        .REFRESH_DIV     (4),
        .ANODE_ACTIVE_LOW(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value_in (value_in),
        .load     (load),
        .busy     (busy),
        .overflow (overflow),
        .digit_out(digit_out),
        .anode    (anode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycles since reset release; scan slot = (cyc / 4) % 4.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_scan(input logic [15:0] bcd);
        int unsigned slot;
        logic [15:0] upper;
        logic [3:0]  exp_digit;
        logic [3:0]  exp_anode;
        slot      = (cyc / 4) % 4;
        upper     = bcd >> (4 * slot);
        exp_digit = upper[3:0];
        exp_anode = ~(4'b0001 << slot);
`ifdef LEADING_ZERO_BLANK_EN
        if (slot != 0 && upper == 16'h0000) exp_anode = 4'b1111;
`endif
        check_eq("digit_out", 32'(digit_out), 32'(exp_digit));
        check_eq("anode", 32'(anode), 32'(exp_anode));
    endtask

    task automatic load_and_check(input logic [13:0] val, input logic [15:0] exp_bcd,
                                  input logic exp_ovf, input int inj_cyc,
                                  input logic [13:0] inj_val);
        int n;
        value_in = val;
        load     = 1'b1;
        tick();
        load = 1'b0;
        n    = 0;
        while (busy === 1'b1 && n < 100) begin
            check_scan(cur_bcd);
            check_eq("ovf_hold", 32'(overflow), 32'(cur_ovf));
            if (n == inj_cyc) begin
                value_in = inj_val;
                load     = 1'b1;
            end else begin
                load = 1'b0;
            end
            n++;
            tick();
        end
        load = 1'b0;
        check_eq("busy_len", 32'(n), 32'd14);
        check_eq("overflow", 32'(overflow), 32'(exp_ovf));
        cur_bcd = exp_bcd;
        cur_ovf = exp_ovf;
        repeat (20) begin
            check_scan(cur_bcd);
            check_eq("busy_idle", 32'(busy), 32'd0);
            tick();
        end
    endtask

    initial begin
        int n;
        rst_n    = 1'b1;
        load     = 1'b0;
        value_in = '0;

        // Asynchronous reset asserted mid-cycle
        #12 rst_n = 1'b0;
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_digit", 32'(digit_out), 32'd0);
        check_eq("rst_anode", 32'(anode), 32'hE);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (6) begin
            check_scan(16'h0000);
            tick();
        end

        // Normal conversion and scan
        load_and_check(14'd1234, 16'h1234, 1'b0, -1, '0);
        // Overflow then in-range value clears it
        load_and_check(14'd16383, 16'h9999, 1'b1, -1, '0);
        load_and_check(14'd5, 16'h0005, 1'b0, -1, '0);
        // Load during busy is ignored
        load_and_check(14'd42, 16'h0042, 1'b0, 2, 14'd7);
        // Set overflow again so the abort must clear it
        load_and_check(14'd16383, 16'h9999, 1'b1, -1, '0);

        // Reset on the 6th busy cycle of converting 9999
        value_in = 14'd9999;
        load     = 1'b1;
        tick();
        load = 1'b0;
        n    = 0;
        while (busy === 1'b1 && n < 5) begin
            check_scan(cur_bcd);
            n++;
            tick();
        end
        check_eq("abort_reach", 32'(n), 32'd5);
        check_eq("abort_busy_pre", 32'(busy), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_ovf", 32'(overflow), 32'd0);
        check_eq("abort_digit", 32'(digit_out), 32'd0);
        check_eq("abort_anode", 32'(anode), 32'hE);
        cur_bcd = 16'h0000;
        cur_ovf = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (10) begin
            check_scan(16'h0000);
            check_eq("abort_idle", 32'(busy), 32'd0);
            tick();
        end

        // Fresh conversion after abort
        load_and_check(14'd9999, 16'h9999, 1'b0, -1, '0);
        // Zero value (only slot 0 lit when blanking)
        load_and_check(14'd0, 16'h0000, 1'b0, -1, '0);
        load_and_check(14'd42, 16'h0042, 1'b0, -1, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
